gray_gradient: RTL
==================

GRAY_GRADIENT -- requirements
Module: gray_gradient

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (supported range 4..2048).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (supported range 4..2048).
REQ-003 SHALL have port iCLK  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port iReset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iGray  input  8  grayscale pixel from the upstream RGB-to-gray stage.
REQ-006 SHALL have port iDval  input  1  iGray valid this cycle; raster order; gaps allowed.
REQ-007 SHALL have port iSof  input  1  start-of-frame pulse; next valid pixel becomes (col 0, row 0).
REQ-008 SHALL have port oGx  output  11  signed horizontal Sobel gradient, two's complement.
REQ-009 SHALL have port oGy  output  11  signed vertical Sobel gradient, two's complement.
REQ-010 SHALL have port oMag  output  11  unsigned |oGx|+|oGy|.
REQ-011 SHALL have port oDval  output  1  oGx/oGy/oMag valid this cycle.

Function
REQ-012 SHALL keep col and row counters, advanced only on iDval; col wraps IMG_WIDTH-1 -> 0 and increments row; row wraps IMG_HEIGHT-1 -> 0.
REQ-013 SHALL clear col and row to 0 on iSof; if iSof and iDval coincide, that pixel is (0,0).
REQ-014 SHALL hold two line buffers of IMG_WIDTH x 8 bits, addressed by col, read and written on the same iDval cycle to supply rows y-1 and y-2.
REQ-015 SHALL hold a 3x3 window register array, shifted one column per iDval only; it does not move while iDval is low.
REQ-016 SHALL compute Gx = (p02+2*p12+p22)-(p00+2*p10+p20) and Gy = (p20+2*p21+p22)-(p00+2*p01+p02), pRC = row R (0 = oldest), column C (0 = oldest), full 11-bit signed, no saturation (range -1020..+1020).
REQ-017 SHALL compute oMag = |Gx|+|Gy| in 11 bits unsigned (max 2040, no overflow).
REQ-018 SHALL produce exactly one output per accepted input pixel; input at (col,row) yields gradient centred at (col-1,row-1).
REQ-019 SHALL output oGx=oGy=oMag=0 with oDval=1 when input col<2 or row<2 (window crosses border or line wrap).
REQ-020 SHALL have fixed latency 2: iDval at edge N -> oDval=1 with result at edge N+2, independent of gaps.
REQ-021 SHALL drive oDval=0 on every cycle not matching REQ-020; oGx/oGy/oMag hold last value when oDval=0.
REQ-022 SHALL not stall or drop pixels; block has no backpressure.

Reset
REQ-023 SHALL on iReset_n low asynchronously clear col, row, window registers, valid pipeline, oGx, oGy, oMag and oDval to 0.
REQ-024 SHALL not require line-buffer memory clearing; border zeroing (REQ-019) masks stale contents after reset.
REQ-025 SHALL treat the first valid pixel after reset release as (0,0) without needing iSof.
REQ-026 SHALL discard any in-flight results on reset mid-frame; no oDval pulses for pre-reset pixels.

Configuration
REQ-027 SHALL honour macro GRADIENT_MAG_EN: defined -> oMag per REQ-017; undefined -> oMag constant 0, abs/add logic removed, oGx/oGy/oDval and latency unchanged.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, GRADIENT_MAG_EN defined unless stated)
REQ-028 SHALL cover reset: assert iReset_n low mid-frame -> all outputs 0 at once; next pixel after release counted (0,0); no stale oDval.
REQ-029 SHALL cover flat frame: 48 pixels of 100, continuous iDval -> 48 oDval pulses, all oGx=oGy=oMag=0, first pulse 2 cycles after first iDval.
REQ-030 SHALL cover vertical edge: cols 0-3 = 0, cols 4-7 = 200 -> centres (3,r) and (4,r), r>=1: oGx=+800, oGy=0, oMag=800; other centres 0.
REQ-031 SHALL cover horizontal edge: rows 0-2 = 50, rows 3-5 = 250 -> centres (c,2) and (c,3), c>=1: oGy=+800, oGx=0, oMag=800.
REQ-032 SHALL cover gaps: REQ-030 stimulus with iDval high every third cycle -> identical result sequence, each oDval exactly 2 cycles after its iDval.
REQ-033 SHALL cover config/resync: GRADIENT_MAG_EN undefined, REQ-030 stimulus -> oMag=0, oGx=+800; iSof mid-row -> counters restart, next two rows give zero outputs.

Source files
------------

// File: rtl/gray_gradient.sv
// Streaming 3x3 Sobel gradient on a raster grayscale pixel stream, fixed 2-cycle latency.
// Optional magnitude output |Gx|+|Gy| is built only when GRADIENT_MAG_EN is defined.
module gray_gradient #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               iCLK,
  input  logic               iReset_n,
  input  logic [7:0]         iGray,
  input  logic               iDval,
  input  logic               iSof,
  output logic signed [10:0] oGx,
  output logic signed [10:0] oGy,
  output logic [10:0]        oMag,
  output logic               oDval
);

  localparam int DATA_W = 8;
  localparam int GRAD_W = 11;
  localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // a + 2b + c over one window edge; always non-negative, max 1020
  function automatic logic signed [GRAD_W-1:0] sum3(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [DATA_W-1:0] c);
    logic signed [GRAD_W-1:0] ea, eb, ec;
    ea = $signed({3'b000, a});
    eb = $signed({2'b00, b, 1'b0});
    ec = $signed({3'b000, c});
    return ea + eb + ec;
  endfunction

`ifdef GRADIENT_MAG_EN
  function automatic logic [GRAD_W-1:0] abs_g(input logic signed [GRAD_W-1:0] a);
    logic signed [GRAD_W-1:0] neg;
    neg = -a;
    return a[GRAD_W-1] ? $unsigned(neg) : $unsigned(a);
  endfunction
`endif

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          border_c;

  // A start-of-frame pulse forces the pixel arriving in the same cycle to (0,0)
  always_comb begin
    col_eff = iSof ? '0 : col_q;
    row_eff = iSof ? '0 : row_q;
    col_d   = col_eff;
    row_d   = row_eff;
    if (iDval) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
      end
    end
    border_c = (col_eff < CW'(2)) || (row_eff < RW'(2));
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers: lb1 holds row y-1, lb2 row y-2; not reset, border masking hides stale data
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb2_q [IMG_WIDTH];
  logic [DATA_W-1:0] up1_c, up2_c;

  assign up1_c = lb1_q[col_eff];
  assign up2_c = lb2_q[col_eff];

  always_ff @(posedge iCLK) begin
    if (iDval) begin
      lb1_q[col_eff] <= iGray;
      lb2_q[col_eff] <= up1_c;
    end
  end

  // ---- stage p0: window shift, border flag captured with the pixel ----
  logic [DATA_W-1:0] win_q [3][3];
  logic              vld_p0, border_p0;

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      vld_p0    <= 1'b0;
      border_p0 <= 1'b0;
    end else begin
      vld_p0 <= iDval;
      if (iDval) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= up2_c;
        win_q[1][2] <= up1_c;
        win_q[2][2] <= iGray;
        border_p0   <= border_c;
      end
    end
  end

  // ---- stage p1: Sobel kernels from the window as it stood after p0 ----
  logic signed [GRAD_W-1:0] gx_c, gy_c;
  logic signed [GRAD_W-1:0] gx_p1, gy_p1;
  logic                     vld_p1;

  always_comb begin
    gx_c = sum3(win_q[0][2], win_q[1][2], win_q[2][2])
         - sum3(win_q[0][0], win_q[1][0], win_q[2][0]);
    gy_c = sum3(win_q[2][0], win_q[2][1], win_q[2][2])
         - sum3(win_q[0][0], win_q[0][1], win_q[0][2]);
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      vld_p1 <= 1'b0;
      gx_p1  <= '0;
      gy_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        gx_p1 <= border_p0 ? '0 : gx_c;
        gy_p1 <= border_p0 ? '0 : gy_c;
      end
    end
  end

  // ---- stage p2: registered outputs, held while no result is valid ----
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      oDval <= 1'b0;
      oGx   <= '0;
      oGy   <= '0;
    end else begin
      oDval <= vld_p1;
      if (vld_p1) begin
        oGx <= gx_p1;
        oGy <= gy_p1;
      end
    end
  end

`ifdef GRADIENT_MAG_EN
  logic [GRAD_W-1:0] mag_c;
  assign mag_c = abs_g(gx_p1) + abs_g(gy_p1);

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      oMag <= '0;
    end else if (vld_p1) begin
      oMag <= mag_c;
    end
  end
`else
  assign oMag = '0;
`endif

endmodule
